// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand forwarding control for a 5-stage pipeline.
// The unit keeps a shadow copy of the register-write metadata for the EX, MEM
// and WB stages. From that copy it detects load-use hazards against the
// instruction in decode, and it selects forwarding sources for the EX operands.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   rs_dec, rt_dec, rd_dec     register specifiers of the instruction in decode
//   uses_rs_dec, uses_rt_dec   decode instruction reads rs / rt
//   RegDest_dec                1: destination is rd_dec, 0: destination is rt_dec
//   RegWrite_dec               decode instruction writes the register file
//   MemToReg_dec               decode instruction is a load
//   branch_taken_ex            branch resolved taken in EX this cycle
//   stall_dec                  hold PC and IF/ID, bubble ID/EX (load-use)
//   flush_dec                  zero IF/ID and ID/EX (taken branch)
//   forwardA_ex, forwardB_ex   operand selects: 00 regfile, 10 MEM, 01 WB
//   stall_count, flush_count   saturating event counters
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_dec,
    input  logic [REG_W-1:0] rt_dec,
    input  logic [REG_W-1:0] rd_dec,
    input  logic             uses_rs_dec,
    input  logic             uses_rt_dec,
    input  logic             RegDest_dec,
    input  logic             RegWrite_dec,
    input  logic             MemToReg_dec,
    input  logic             branch_taken_ex,
    output logic             stall_dec,
    output logic             flush_dec,
    output logic [1:0]       forwardA_ex,
    output logic [1:0]       forwardB_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Register-write metadata carried by every shadow stage.
    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] dest;
    } wr_meta_t;

    // The EX entry also remembers which sources the instruction reads.
    typedef struct packed {
        wr_meta_t         meta;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
    } ex_entry_t;

    ex_entry_t ex_q;
    ex_entry_t ex_d;
    wr_meta_t  mem_q;
    wr_meta_t  wb_q;

    logic [REG_W-1:0] dest_dec;
    logic             load_use;

    // Register 0 is hard-wired, so a write to it is never a hazard or a source.
    function automatic logic is_writing(input wr_meta_t m);
        return m.valid & m.regwrite & (m.dest != '0);
    endfunction

    // MEM wins over WB because it holds the younger producer. A load sitting
    // in MEM has no data yet; the load-use stall keeps that case out of EX.
    function automatic logic [1:0] fwd_sel(input logic             ex_valid,
                                           input logic [REG_W-1:0] src,
                                           input logic             uses_src,
                                           input wr_meta_t         mem,
                                           input wr_meta_t         wb);
        if (!ex_valid)
            return FWD_REG;
        if (is_writing(mem) && !mem.memtoreg && uses_src && (mem.dest == src))
            return FWD_MEM;
        if (is_writing(wb) && (wb.dest == src))
            return FWD_WB;
        return FWD_REG;
    endfunction

    // ------------------------------------------------------------------------
    // Hazard detection and the next EX entry
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        dest_dec = RegDest_dec ? rd_dec : rt_dec;

        load_use = is_writing(ex_q.meta) & ex_q.meta.memtoreg &
                   ((uses_rs_dec & (ex_q.meta.dest == rs_dec)) |
                    (uses_rt_dec & (ex_q.meta.dest == rt_dec)));

        // NOTE: flush comes straight from an input, so it is masked by reset
        // here; the stall needs no mask because ex_q is already cleared.
        flush_dec = branch_taken_ex & reset;
        // A taken branch discards the consumer anyway, so flush beats stall.
        stall_dec = load_use & ~branch_taken_ex;

        ex_d = '0;
        if (!(stall_dec || flush_dec)) begin
            ex_d.meta.valid    = 1'b1;
            ex_d.meta.regwrite = RegWrite_dec;
            ex_d.meta.memtoreg = MemToReg_dec;
            ex_d.meta.dest     = dest_dec;
            ex_d.rs            = rs_dec;
            ex_d.rt            = rt_dec;
            ex_d.uses_rs       = uses_rs_dec;
            ex_d.uses_rt       = uses_rt_dec;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selects for the instruction currently in EX
    // ------------------------------------------------------------------------
    always_comb begin
        forwardA_ex = fwd_sel(ex_q.meta.valid, ex_q.rs, ex_q.uses_rs, mem_q, wb_q);
        forwardB_ex = fwd_sel(ex_q.meta.valid, ex_q.rt, ex_q.uses_rt, mem_q, wb_q);
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline and saturating counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            // NOTE: non-blocking assignments let MEM take the old EX value and
            // WB the old MEM value within the same edge.
            ex_q  <= ex_d;
            mem_q <= ex_q.meta;
            wb_q  <= mem_q;

            if (stall_dec && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_dec && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// Bench for hazard_forward_unit. A driver applies one decode vector per cycle
// and pushes the hand-computed response into a scoreboard queue. A monitor
// pops one entry at each falling edge and compares it with the DUT outputs.
// A second instance with CNT_W=4 shares the inputs and shows saturation.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_dec, rt_dec, rd_dec;
    logic       uses_rs_dec, uses_rt_dec, RegDest_dec, RegWrite_dec, MemToReg_dec;
    logic       branch_taken_ex;

    logic        stall_dec, flush_dec;
    logic [1:0]  forwardA_ex, forwardB_ex;
    logic [15:0] stall_count, flush_count;

    logic        stall4, flush4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  sc4, fc4;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs_dec(rs_dec), .rt_dec(rt_dec), .rd_dec(rd_dec),
        .uses_rs_dec(uses_rs_dec), .uses_rt_dec(uses_rt_dec),
        .RegDest_dec(RegDest_dec), .RegWrite_dec(RegWrite_dec),
        .MemToReg_dec(MemToReg_dec), .branch_taken_ex(branch_taken_ex),
        .stall_dec(stall_dec), .flush_dec(flush_dec),
        .forwardA_ex(forwardA_ex), .forwardB_ex(forwardB_ex),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_forward_unit #(.REG_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .rs_dec(rs_dec), .rt_dec(rt_dec), .rd_dec(rd_dec),
        .uses_rs_dec(uses_rs_dec), .uses_rt_dec(uses_rt_dec),
        .RegDest_dec(RegDest_dec), .RegWrite_dec(RegWrite_dec),
        .MemToReg_dec(MemToReg_dec), .branch_taken_ex(branch_taken_ex),
        .stall_dec(stall4), .flush_dec(flush4),
        .forwardA_ex(fa4), .forwardB_ex(fb4),
        .stall_count(sc4), .flush_count(fc4)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Expected counter values, advanced from the hand-computed stall/flush.
    logic [15:0] m_sc = '0, m_fc = '0;
    logic [3:0]  m_sc4 = '0, m_fc4 = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".stall"},   16'(stall_dec),   16'(e.stall));
                check({e.name, ".flush"},   16'(flush_dec),   16'(e.flush));
                check({e.name, ".fwdA"},    16'(forwardA_ex), 16'(e.fa));
                check({e.name, ".fwdB"},    16'(forwardB_ex), 16'(e.fb));
                check({e.name, ".scnt"},    stall_count,      e.sc);
                check({e.name, ".fcnt"},    flush_count,      e.fc);
                check({e.name, ".stall4"},  16'(stall4),      16'(e.stall));
                check({e.name, ".flush4"},  16'(flush4),      16'(e.flush));
                check({e.name, ".fwdA4"},   16'(fa4),         16'(e.fa));
                check({e.name, ".fwdB4"},   16'(fb4),         16'(e.fb));
                check({e.name, ".scnt4"},   16'(sc4),         16'(e.sc4));
                check({e.name, ".fcnt4"},   16'(fc4),         16'(e.fc4));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic urs, input logic urt, input logic rdst,
                           input logic rw, input logic m2r);
        rs_dec = rs; rt_dec = rt; rd_dec = rd;
        uses_rs_dec = urs; uses_rt_dec = urt;
        RegDest_dec = rdst; RegWrite_dec = rw; MemToReg_dec = m2r;
    endtask

    task automatic nop();
        set_dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_dec(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [4:0] rt, input logic [4:0] base);
        set_dec(base, rt, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Push the expected response for the cycle just driven.
    task automatic expect_cyc(input string name, input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        if (!reset) begin
            m_sc = '0; m_fc = '0; m_sc4 = '0; m_fc4 = '0;
        end
        e.name = name; e.stall = st; e.flush = fl; e.fa = fa; e.fb = fb;
        e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
        sb_q.push_back(e);
        if (st) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc4 != 4'hF)    m_sc4 = m_sc4 + 4'd1;
        end
        if (fl) begin
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (m_fc4 != 4'hF)    m_fc4 = m_fc4 + 4'd1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        branch_taken_ex = 1'b1;
        load(5'd7, 5'd7);

        // Reset held with arbitrary inputs: everything reads zero.
        tick(); expect_cyc("rst0", 0, 0, 2'b00, 2'b00);
        tick(); expect_cyc("rst1", 0, 0, 2'b00, 2'b00);

        tick(); reset = 1'b1; branch_taken_ex = 1'b0; nop();
        expect_cyc("post_rst", 0, 0, 2'b00, 2'b00);

        // ALU back-to-back: add r3<-r1,r2 ; sub r4<-r3,r5
        tick(); rtype(5'd3, 5'd1, 5'd2); expect_cyc("b2b_first_ex", 0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd4, 5'd3, 5'd5); expect_cyc("b2b_add_ex",   0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("b2b_sub_ex",   0, 0, 2'b10, 2'b00);

        // One independent instruction in between -> WB forwarding; then rt from MEM.
        tick(); rtype(5'd3, 5'd1, 5'd2); expect_cyc("gap_c4", 0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd6, 5'd1, 5'd2); expect_cyc("gap_c5", 0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd4, 5'd3, 5'd5); expect_cyc("gap_c6", 0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd9, 5'd5, 5'd4); expect_cyc("gap_sub_ex", 0, 0, 2'b01, 2'b00);
        tick(); nop();                   expect_cyc("rt_mem_fwd", 0, 0, 2'b00, 2'b10);

        // Load-use: lw r7 ; add r8<-r7,r1 -> one stall, then WB forwarding.
        tick(); load(5'd7, 5'd1);        expect_cyc("lu_lw",     0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd8, 5'd7, 5'd1); expect_cyc("lu_stall",  1, 0, 2'b00, 2'b00);
        tick();                          expect_cyc("lu_bubble", 0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("lu_add_ex", 0, 0, 2'b01, 2'b00);

        // Register zero is never a source or a hazard.
        tick(); rtype(5'd0, 5'd1, 5'd2); expect_cyc("r0_c13",   0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd5, 5'd0, 5'd0); expect_cyc("r0_c14",   0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("r0_fwd",   0, 0, 2'b00, 2'b00);
        tick(); load(5'd0, 5'd1);        expect_cyc("r0_lw",    0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd5, 5'd0, 5'd1); expect_cyc("r0_nostall", 0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("r0_c18",   0, 0, 2'b00, 2'b00);

        // Branch in the same cycle as a load-use: flush only.
        tick(); load(5'd7, 5'd1);        expect_cyc("br_lw",    0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd8, 5'd7, 5'd1); branch_taken_ex = 1'b1;
        expect_cyc("br_flush", 0, 1, 2'b00, 2'b00);
        tick(); nop(); branch_taken_ex = 1'b0;
        expect_cyc("br_bubble", 0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("br_after", 0, 0, 2'b00, 2'b00);

        // Saturation: lw r7,(r7) held in decode stalls every other cycle.
        tick(); load(5'd7, 5'd7);        expect_cyc("sat_start", 0, 0, 2'b00, 2'b00);
        for (int i = 0; i < 20; i++) begin
            tick(); expect_cyc($sformatf("sat_stall%0d", i), 1, 0,
                               (i == 0) ? 2'b00 : 2'b01, (i == 0) ? 2'b00 : 2'b01);
            tick(); expect_cyc($sformatf("sat_bub%0d", i), 0, 0, 2'b00, 2'b00);
        end
        tick(); nop();                   expect_cyc("sat_end0", 0, 0, 2'b01, 2'b01);
        tick(); nop();                   expect_cyc("sat_end1", 0, 0, 2'b00, 2'b00);

        // Reset asserted in the middle of a stall cycle.
        tick(); load(5'd7, 5'd1);        expect_cyc("mr_lw",   0, 0, 2'b00, 2'b00);
        tick(); rtype(5'd8, 5'd7, 5'd1); reset = 1'b0;
        expect_cyc("mr_reset", 0, 0, 2'b00, 2'b00);
        tick(); reset = 1'b1; nop();     expect_cyc("mr_release", 0, 0, 2'b00, 2'b00);
        tick(); nop();                   expect_cyc("mr_idle",    0, 0, 2'b00, 2'b00);

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drain", 16'(sb_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline. It sits alongside the decode→execute control register and consumes the same decode-stage control signals.
- Keeps its own shadow pipeline (EX, MEM, WB) of register-write metadata.
- Drives decode stall and flush so that a bubble is inserted into the decode→execute register.
- Drives the EX-stage operand forwarding selects.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rs_dec  input  REG_W  source register A of the instruction in decode
- rt_dec  input  REG_W  source register B / I-type destination in decode
- rd_dec  input  REG_W  R-type destination in decode
- uses_rs_dec  input  1  decode instruction reads rs
- uses_rt_dec  input  1  decode instruction reads rt
- RegDest_dec  input  1  1 selects rd_dec as destination, 0 selects rt_dec
- RegWrite_dec  input  1  decode instruction writes the register file
- MemToReg_dec  input  1  decode instruction is a load
- branch_taken_ex  input  1  branch resolved taken in EX this cycle
- stall_dec  output  1  hold PC and the fetch/decode register; bubble the decode→execute register
- flush_dec  output  1  zero the fetch/decode and decode→execute registers
- forwardA_ex  output  2  operand A select: 00 register file, 10 MEM stage, 01 WB stage
- forwardB_ex  output  2  operand B select, same encoding
- stall_count  output  CNT_W  load-use stall cycles seen, saturating
- flush_count  output  CNT_W  branch flushes seen, saturating

Behaviour:
- Stage entries:
  - Each of EX, MEM, WB holds {valid, regwrite, memtoreg, dest[REG_W]}.
  - EX additionally holds {rs, rt, uses_rs, uses_rt}.
  - dest_dec = RegDest_dec ? rd_dec : rt_dec.
- Reset (reset=0, asynchronous):
  - All stage entries are cleared to valid=0 and all fields 0.
  - stall_dec, flush_dec, forwardA_ex and forwardB_ex read 0.
  - Both counters read 0.
  - Leaving reset takes effect on the next rising clk.
- Hazard conditions:
  - A stage entry is "writing" when valid & regwrite & dest≠0.
  - Register 0 is never a hazard and never a forwarding source.
  - load_use (combinational) = EX writing & EX.memtoreg & ((uses_rs_dec & EX.dest==rs_dec) | (uses_rt_dec & EX.dest==rt_dec)).
- Outputs:
  - flush_dec = branch_taken_ex, combinational.
  - stall_dec = load_use & ~branch_taken_ex. Flush has priority over stall.
- Advance on each rising clk:
  - WB ← MEM and MEM ← EX, unconditionally.
  - EX ← bubble (valid=0) if stall_dec or flush_dec.
  - Otherwise EX ← the decode fields with valid=1.
- Load-use stall length: exactly one cycle. The next cycle EX holds the bubble, so load_use deasserts and the consumer advances; it reaches EX while the load is in WB.
- forwardA_ex:
  - 10 if MEM writing & ~MEM.memtoreg & EX.uses_rs & MEM.dest==EX.rs.
  - Else 01 if WB writing & WB.dest==EX.rs.
  - Else 00.
  - MEM has priority over WB, because it holds the younger producer.
  - Forced to 00 when EX.valid=0.
- forwardB_ex: same rules using EX.rt / EX.uses_rt.
- A load in MEM is never forwarded from MEM (its data is not yet available); the stall guarantees this case never reaches EX.
- Counters:
  - stall_count increments on each clk where stall_dec=1.
  - flush_count increments on each clk where flush_dec=1.
  - Both saturate at all-ones with no wrap.
- Simultaneous branch_taken_ex and load_use: flush only. stall_dec=0, flush_count increments, stall_count does not.
- Reset mid-stall: all state clears immediately; stall_dec drops asynchronously with reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary inputs → all outputs 0; first post-reset instruction enters EX with forwardA_ex/forwardB_ex=00.
- ALU back-to-back:
  - Cycle n: decode "add r3←r1,r2" (RegDest=1, rd=3, RegWrite=1).
  - Cycle n+1: decode "sub r4←r3,r5".
  - → when sub is in EX, forwardA_ex=10. With a second independent instruction between them, forwardA_ex=01 instead.
- Load-use: decode "lw r7" (RegDest=0, rt=7, MemToReg=1), then "add r8←r7,r1" (uses_rs=1, rs=7):
  - stall_dec=1 for exactly one cycle; stall_count 0→1.
  - add reaches EX with forwardA_ex=01.
- Register zero: producer dest=0 with RegWrite=1, consumer rs=0 → forwardA_ex=00; a load to r0 followed by a use of r0 → no stall.
- Branch vs stall: assert branch_taken_ex in the same cycle as a load_use condition → flush_dec=1, stall_dec=0, EX bubble next cycle, flush_count +1, stall_count unchanged.
- Saturation: with CNT_W=4, force 20 consecutive load-use stalls → stall_count holds at 15.
